// File: rtl/alu_operand_seq.sv
//------------------------------------------------------------------------------
// Module   : alu_operand_seq
// Purpose  : Sequences two nibble operands into an external 4-bit ALU. It waits
//            SETTLE cycles and then captures the ALU result and flags.
//            Optional macro ALU_CHAIN_EN takes the carry-in from the captured cf.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_operand_seq #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       load,
  input  logic       op,
  input  logic       c0,
  input  logic       clr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_add_sub,
  output logic       alu_c0,
  input  logic [3:0] alu_f,
  input  logic       alu_c4,
  input  logic       alu_zf,
  input  logic       alu_cf,
  output logic [3:0] result,
  output logic       c4,
  output logic       zf,
  output logic       cf,
  output logic       valid,
  output logic       busy,
  output logic [1:0] state
);

  if ((SETTLE < 1) || (SETTLE > 15)) begin : g_settle_range_check
    $error("alu_operand_seq: SETTLE must be within 1..15");
  end

  localparam logic [3:0] c_settle = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GOT_A = 2'b01,
    S_EXEC  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_load_a;
  logic       w_load_b;
  logic       w_capture;
  logic       w_c0_src;

`ifdef ALU_CHAIN_EN
  // The previous capture's cf feeds the next operation for multi-nibble chaining.
  assign w_c0_src = cf;
`else
  assign w_c0_src = c0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_capture   = 1'b0;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (load) begin
            w_load_a    = 1'b1;
            w_state_nxt = S_GOT_A;
          end
        end
        S_GOT_A: begin
          if (load) begin
            w_load_b    = 1'b1;
            w_cnt_nxt   = c_settle;
            w_state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd1) begin
            w_capture   = 1'b1;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      alu_a       <= 4'd0;
      alu_b       <= 4'd0;
      alu_add_sub <= 1'b0;
      alu_c0      <= 1'b0;
      result      <= 4'd0;
      c4          <= 1'b0;
      zf          <= 1'b0;
      cf          <= 1'b0;
      valid       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      valid   <= w_capture;
      if (w_load_a) begin
        alu_a <= din;
      end
      if (w_load_b) begin
        alu_b       <= din;
        alu_add_sub <= op;
        alu_c0      <= w_c0_src;
      end
      if (w_capture) begin
        result <= alu_f;
        c4     <= alu_c4;
        zf     <= alu_zf;
        cf     <= alu_cf;
      end
    end
  end

  assign busy  = (r_state == S_EXEC);
  assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_operand_seq
// Purpose  : Scoreboard bench for alu_operand_seq. It runs a SETTLE=1 and a
//            SETTLE=3 instance behind a behavioural nibble ALU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_operand_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load, hold3, op, c0, clr;
  logic [3:0] din;

  logic [3:0] alu_a1, alu_b1, alu_f1, result1;
  logic       alu_add_sub1, alu_c01, alu_c41, alu_zf1, alu_cf1, c41, zf1, cf1, valid1, busy1;
  logic [1:0] state1;
  logic [3:0] alu_a3, alu_b3, alu_f3, result3;
  logic       alu_add_sub3, alu_c03, alu_c43, alu_zf3, alu_cf3, c43, zf3, cf3, valid3, busy3;
  logic [1:0] state3;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: add gives a+b+cin; subtract gives a-b-cin with c4 = borrow, cf = ~borrow.
  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic add, input logic cin);
    logic [4:0] s;
    logic       c;
    if (add) begin
      s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      c = s[4];
      return {c, (s[3:0] == 4'd0), c, s[3:0]};
    end
    s = {1'b0, a} - {1'b0, b} - {4'd0, cin};
    c = s[4];
    return {c, (s[3:0] == 4'd0), ~c, s[3:0]};
  endfunction

  assign {alu_c41, alu_zf1, alu_cf1, alu_f1} = alu_fn(alu_a1, alu_b1, alu_add_sub1, alu_c01);
  assign {alu_c43, alu_zf3, alu_cf3, alu_f3} = alu_fn(alu_a3, alu_b3, alu_add_sub3, alu_c03);

  alu_operand_seq #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .load(load), .op(op), .c0(c0), .clr(clr),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_add_sub(alu_add_sub1), .alu_c0(alu_c01),
    .alu_f(alu_f1), .alu_c4(alu_c41), .alu_zf(alu_zf1), .alu_cf(alu_cf1),
    .result(result1), .c4(c41), .zf(zf1), .cf(cf1),
    .valid(valid1), .busy(busy1), .state(state1)
  );

  alu_operand_seq #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .din(din), .load(load | hold3), .op(op), .c0(c0), .clr(clr),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_add_sub(alu_add_sub3), .alu_c0(alu_c03),
    .alu_f(alu_f3), .alu_c4(alu_c43), .alu_zf(alu_zf3), .alu_cf(alu_cf3),
    .result(result3), .c4(c43), .zf(zf3), .cf(cf3),
    .valid(valid3), .busy(busy3), .state(state3)
  );

  typedef struct {
    logic [6:0] flags_res;  // {result, c4, zf, cf}
    int         due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  task automatic pulse_rst;
    @(negedge clk);
    rst = 1'b1; load = 1'b0; clr = 1'b0; hold3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    q3.delete();
  endtask

  // Loads A then B and follows both instances until their captures are checked.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic o, input logic ci,
                       input logic [3:0] ef, input logic ec4, input logic ezf, input logic ecf,
                       input bit hold, input string nm);
    exp_t e;
    int   b3 = 0;
    bit   s1 = 0;
    bit   s3 = 0;
    @(negedge clk);
    din = a; load = 1'b1;
    @(negedge clk);
    din = b; op = o; c0 = ci;
    e.flags_res = {ef, ec4, ezf, ecf};
    e.due = cyc + 2;
    q1.push_back(e);
    e.due = cyc + 4;
    q3.push_back(e);
    @(negedge clk);
    load = 1'b0; hold3 = hold; din = ~b;
    for (int i = 0; i < 8; i++) begin
      if (busy3) begin
        b3++;
        n_vec++;
        if ({alu_a3, alu_b3, alu_add_sub3} !== {a, b, o}) begin
          n_err++;
          $display("FAIL %s exec_operands: got %h/%h/%b want %h/%h/%b", nm,
                   alu_a3, alu_b3, alu_add_sub3, a, b, o);
        end
      end
      if (valid1) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL %s spurious_valid_s1: got valid=1 at cycle %0d want 0", nm, cyc);
        end else begin
          e = q1.pop_front();
          s1 = 1;
          if ({result1, c41, zf1, cf1} !== e.flags_res || cyc != e.due) begin
            n_err++;
            $display("FAIL %s capture_s1: got res/c4/zf/cf=%h/%b/%b/%b at cycle %0d want %h/%b/%b/%b at cycle %0d",
                     nm, result1, c41, zf1, cf1, cyc, e.flags_res[6:3], e.flags_res[2],
                     e.flags_res[1], e.flags_res[0], e.due);
          end
        end
      end
      if (valid3) begin
        hold3 = 1'b0;
        n_vec++;
        if (q3.size() == 0) begin
          n_err++;
          $display("FAIL %s spurious_valid_s3: got valid=1 at cycle %0d want 0", nm, cyc);
        end else begin
          e = q3.pop_front();
          s3 = 1;
          if ({result3, c43, zf3, cf3} !== e.flags_res || cyc != e.due) begin
            n_err++;
            $display("FAIL %s capture_s3: got res/c4/zf/cf=%h/%b/%b/%b at cycle %0d want %h/%b/%b/%b at cycle %0d",
                     nm, result3, c43, zf3, cf3, cyc, e.flags_res[6:3], e.flags_res[2],
                     e.flags_res[1], e.flags_res[0], e.due);
          end
        end
      end
      @(negedge clk);
    end
    hold3 = 1'b0;
    n_vec++;
    if ({s1, s3} !== 2'b11) begin
      n_err++;
      $display("FAIL %s valid_seen: got s1/s3=%b/%b want 1/1", nm, s1, s3);
    end
    if (hold) begin
      n_vec++;
      if (b3 != 3) begin
        n_err++;
        $display("FAIL %s busy_cycles: got %0d want 3", nm, b3);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; hold3 = 1'b0; op = 1'b0; c0 = 1'b0; clr = 1'b0; din = 4'hF;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({state1, alu_a1, alu_b1, alu_add_sub1, alu_c01, result1, c41, zf1, cf1, valid1, busy1} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_s1: got state=%b a=%h b=%h res=%h want all zero", state1, alu_a1, alu_b1, result1);
    end
    n_vec++;
    if ({state3, alu_a3, alu_b3, alu_add_sub3, alu_c03, result3, c43, zf3, cf3, valid3, busy3} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_s3: got state=%b a=%h b=%h res=%h want all zero", state3, alu_a3, alu_b3, result3);
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    pulse_rst();
    do_op(4'd3, 4'd5, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 0, "add_3_5");
    pulse_rst();
    do_op(4'd15, 4'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 0, "add_15_1");
  endtask

  task automatic test_sub;
    pulse_rst();
    do_op(4'd5, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 0, "sub_5_5");
    pulse_rst();
    do_op(4'd3, 4'd5, 1'b0, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 0, "sub_3_5");
  endtask

  task automatic test_settle_lockout;
    pulse_rst();
    do_op(4'd2, 4'd9, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1, "lockout_2_9");
  endtask

  // Runs right after the lockout op, so the retained result is 0xB and alu_b is 9.
  task automatic test_clear;
    @(negedge clk);
    din = 4'd2; load = 1'b1;
    @(negedge clk);
    din = 4'd7; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; load = 1'b0;
    n_vec++;
    if ({state1, state3, valid1, valid3} !== 6'd0) begin
      n_err++;
      $display("FAIL clr_state: got state=%b/%b valid=%b/%b want 00/00 0/0", state1, state3, valid1, valid3);
    end
    n_vec++;
    if ({result1, alu_a1, alu_b1, result3, alu_b3} !== {4'hB, 4'd2, 4'd9, 4'hB, 4'd9}) begin
      n_err++;
      $display("FAIL clr_retain: got res=%h a=%h b=%h res3=%h b3=%h want b 2 9 b 9",
               result1, alu_a1, alu_b1, result3, alu_b3);
    end
  endtask

  task automatic test_rst_mid_exec;
    bit seen = 0;
    @(negedge clk);
    din = 4'd4; load = 1'b1;
    @(negedge clk);
    din = 4'd6; op = 1'b1; c0 = 1'b1;
    @(negedge clk);
    load = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    q3.delete();
    n_vec++;
    if ({state1, alu_a1, alu_b1, alu_add_sub1, alu_c01, result1, c41, zf1, cf1, valid1, busy1,
         state3, alu_a3, alu_b3, alu_add_sub3, alu_c03, result3, c43, zf3, cf3, valid3, busy3} !== 42'd0) begin
      n_err++;
      $display("FAIL rst_mid_exec_zero: got state=%b/%b res=%h/%h busy=%b/%b want all zero",
               state1, state3, result1, result3, busy1, busy3);
    end
    for (int i = 0; i < 5; i++) begin
      if (valid1 || valid3) seen = 1;
      @(negedge clk);
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_exec_valid: got valid pulse=1 want 0");
    end
  endtask

  task automatic test_back_to_back_chain;
    pulse_rst();
    do_op(4'd5, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 0, "chain_sub_5_5");
`ifdef ALU_CHAIN_EN
    do_op(4'd1, 4'd1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 0, "chain_add_1_1");
`else
    do_op(4'd1, 4'd1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 0, "chain_add_1_1");
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_settle_lockout();
    test_clear();
    test_rst_mid_exec();
    test_back_to_back_chain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/alu_operand_seq.md
ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 1: cycles allowed for the ALU to settle before capture; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port din, input, 4 bits: operand nibble.
REQ-005 SHALL have port load, input, 1 bit: sample din as the next operand; level-sampled each edge.
REQ-006 SHALL have port op, input, 1 bit: 1 = add, 0 = subtract; sampled with operand B.
REQ-007 SHALL have port c0, input, 1 bit: carry/borrow-in; sampled with operand B.
REQ-008 SHALL have port clr, input, 1 bit: synchronous abort to IDLE.
REQ-009 SHALL have ports alu_a, alu_b, output, 4 bits each: registered operands to the ALU.
REQ-010 SHALL have ports alu_add_sub and alu_c0, output, 1 bit each: registered mode and carry-in to the ALU.
REQ-011 SHALL have ports alu_f (4 bits), alu_c4, alu_zf and alu_cf (1 bit each), all inputs: ALU results.
REQ-012 SHALL have port result, output, 4 bits: captured alu_f.
REQ-013 SHALL have ports c4, zf and cf, output, 1 bit each: captured flags.
REQ-014 SHALL have port valid, output, 1 bit: one-cycle pulse on each new capture.
REQ-015 SHALL have port busy, output, 1 bit: high in EXEC.
REQ-016 SHALL have port state, output, 2 bits: IDLE=00, GOT_A=01, EXEC=10, DONE=11.

Function
REQ-017 In IDLE, load=1 SHALL register din into alu_a and move to GOT_A.
REQ-018 In GOT_A, load=1 SHALL register din into alu_b, op into alu_add_sub and the carry-in source into alu_c0, load the settle counter with SETTLE, and move to EXEC.
REQ-019 In EXEC, on each edge the block SHALL, if counter==1, capture alu_f/alu_c4/alu_zf/alu_cf into result/c4/zf/cf, pulse valid and move to DONE; otherwise it SHALL decrement the counter.
REQ-020 Latency: with operand B sampled at edge k, results SHALL be visible and valid=1 after edge k+SETTLE.
REQ-021 In DONE, load=1 SHALL register din into alu_a, keep result/flags unchanged, and move to GOT_A.
REQ-022 In EXEC, load SHALL be ignored; alu_a/alu_b/alu_add_sub/alu_c0 SHALL remain stable throughout EXEC.
REQ-023 valid SHALL be high for exactly one cycle per capture; busy SHALL equal (state==EXEC).
REQ-024 clr=1 in any state SHALL force IDLE, valid=0 and counter=0; operands and result/flags SHALL be retained.
REQ-025 When clr=1 and load=1 on the same edge, clr SHALL take priority and din SHALL be discarded.
REQ-026 result and flags SHALL change only on capture or reset.
REQ-027 Counter width SHALL be 4 bits; SETTLE outside 1..15 SHALL be rejected by elaboration-time check.

Reset
REQ-028 rst=1 SHALL set state to IDLE and clear counter, alu_a, alu_b, alu_add_sub, alu_c0, result, c4, zf, cf, valid and busy to 0.
REQ-029 rst SHALL take priority over clr and load; reset mid-EXEC SHALL abort without capture.

Configuration
REQ-030 When macro ALU_CHAIN_EN is defined, alu_c0 SHALL be loaded from the registered cf (multi-nibble chaining) and the c0 input SHALL be ignored.
REQ-031 When ALU_CHAIN_EN is undefined, alu_c0 SHALL be loaded from the c0 input.

Verification
REQ-032 Add: SETTLE=1; din=3 then din=5, op=1, c0=0 -> result=8, c4=0, zf=0, cf=0; valid pulse one edge after B is sampled.
REQ-033 Add with carry-out: 15 + 1, op=1, c0=0 -> result=0, c4=1, zf=1, cf=1.
REQ-034 Subtract: 5 - 5, op=0, c0=0 -> result=0, zf=1, c4=0, cf=1; 3 - 5 -> result=0xE, c4=1, cf=0.
REQ-035 Timing and EXEC lockout: SETTLE=3; load held high through EXEC -> operands unchanged, busy high 3 cycles, valid exactly 3 edges after B is sampled.
REQ-036 Clear and reset: clr with load in GOT_A -> state=00, prior result retained; rst mid-EXEC -> all outputs 0, no valid pulse.
REQ-037 Chaining: with ALU_CHAIN_EN defined, 5 - 5 (cf=1), then 1 + 1 with op=1 and c0 input=0 -> result=3; without ALU_CHAIN_EN -> result=2.
